frame_sequencer: RTL
====================

# frame_sequencer

APU frame sequencer: divides the CPU-rate clock into quarter-frame (~240 Hz) and half-frame (~120 Hz) strobes that clock the linear, length and envelope counters of every channel, including the `triangle` block's `enable_240hz` input. It implements the $4017 frame counter: 4-step or 5-step sequence, sequence restart on register write, and the frame interrupt. It sits beside the register file and fans its strobes out to all channel blocks.

## Interface
- `QUARTER_CYCLES`, default 7457: clk cycles per sequencer step. Legal range is 2..65535.
- `clk`  in  1: APU clock, 1.79 MHz CPU rate.
- `rst`  in  1: asynchronous, active-high reset.
- `reg_4017`  in  8: frame counter register. Bit 7 is the mode (0 = 4-step, 1 = 5-step). Bit 6 is IRQ inhibit.
- `reg_4017_event`  in  1: one-cycle write strobe for $4017.
- `status_read`  in  1: one-cycle strobe for a $4015 read; clears the IRQ flag.
- `enable_240hz`  out  1: quarter-frame strobe, one clk wide.
- `enable_120hz`  out  1: half-frame strobe, one clk wide.
- `frame_irq`  out  1: frame interrupt flag, level.

## Operation
- Mode and inhibit are captured into internal registers on `reg_4017_event`. `reg_4017` is ignored at all other times.
- Divider: a 16-bit counter runs from 0 to `QUARTER_CYCLES`-1, then wraps to 0. Each wrap is a step tick.
- Step counter (this is the FSM state):
  - 4-step mode: S0→S1→S2→S3→S0.
  - 5-step mode: S0→S1→S2→S3→S4→S0.
  - The state advances on each step tick.
- Strobes on a step tick, keyed by the state being left:
  - 4-step mode: quarter on S0, S1, S2, S3. Half on S1 and S3. IRQ set on S3 when inhibit = 0.
  - 5-step mode: quarter on S0, S1, S2, S4. Half on S1 and S4. S3 emits nothing. IRQ is never set.
- Write event:
  - Divider is cleared to 0 and the state returns to S0.
  - If the new mode is 5-step, one quarter strobe and one half strobe are emitted immediately.
  - If the new inhibit = 1, `frame_irq` clears.
- IRQ flag clear sources: `status_read`, a write with inhibit = 1, and `rst`.
- Simultaneous set and `status_read` in the same cycle: set wins and the flag stays 1.
- Simultaneous write event and step tick: the write wins. The tick's strobes and IRQ set are suppressed; only the write's own strobes, if any, are produced.
- `rst` mid-frame: all state is cleared immediately, with no strobe emitted.

## Timing
- Reset values:
  - `enable_240hz` = 0, `enable_120hz` = 0, `frame_irq` = 0.
  - Divider = 0, state = S0, mode = 4-step, inhibit = 0.
- All outputs are registered.
- A step tick occurring in cycle N produces strobes high in cycle N+1 only.
- The IRQ flag is 1 from cycle N+1.
- A write event in cycle N:
  - Divider is 0 in cycle N+1.
  - The 5-step immediate strobes are high in cycle N+1.
  - The first regular tick occurs at cycle N+`QUARTER_CYCLES`, so its strobes appear at N+`QUARTER_CYCLES`+1.
- Strobe spacing in steady state is exactly `QUARTER_CYCLES` clk cycles. A 4-step frame lasts 4×`QUARTER_CYCLES` cycles; a 5-step frame lasts 5×.
- `status_read` in cycle N gives `frame_irq` = 0 in N+1, unless a set coincides in cycle N.

## Configuration
- `FRAME_IRQ_EN` defined: the IRQ flag, its set/clear logic and `status_read` handling are compiled in.
- `FRAME_IRQ_EN` undefined:
  - `frame_irq` is tied to 0.
  - The inhibit bit and `status_read` are ignored.
  - No flag register exists.
  - Strobe behaviour is identical in both builds.

## Structure
- Shared package `apu_pkg` holds:
  - The default `QUARTER_CYCLES` constant.
  - The step-state typedef (S0–S4).
  - The mode encoding (`MODE_4STEP` = 0, `MODE_5STEP` = 1).
  - Bit-position constants for $4017 (mode = 7, inhibit = 6).
- Sub-module `frame_divider` holds the parameterized prescaler. It has a sync clear input and produces a one-cycle `tick` output. The parent owns the FSM, strobes and IRQ.

## Test plan
Run with `QUARTER_CYCLES` = 4 unless stated otherwise.
- After `rst`, with no writes: `enable_240hz` pulses at cycles 5, 9, 13, 17. `enable_120hz` pulses at cycles 9 and 17. `frame_irq` rises at cycle 17 and stays high.
- At IRQ high, assert `status_read` for one cycle: `frame_irq` = 0 next cycle and rises again 16 cycles later. Assert `status_read` on the set cycle: the flag stays 1.
- Write $80 (5-step): both strobes appear the next cycle. Then quarter pulses appear at +4, +8, +12, a gap at +16, and +20. Half pulses appear at +8 and +20. `frame_irq` never rises.
- Write $40 while `frame_irq` = 1: flag clears next cycle. It stays 0 across 3 full 4-step frames.
- Write $00 on the same cycle as a step tick: no tick strobe occurs. The next quarter pulse arrives 4 cycles later.
- Assert `rst` mid-frame while a strobe is pending: all outputs go to 0 asynchronously. The sequence restarts from S0 after release. Repeat with `FRAME_IRQ_EN` undefined: `frame_irq` is constant 0.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared APU definitions: frame-sequencer step states, $4017 field positions
// and the default prescaler length.
package apu_pkg;

    localparam int QUARTER_CYCLES_DEFAULT = 7457;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } step_e;

    localparam logic MODE_4STEP = 1'b0;
    localparam logic MODE_5STEP = 1'b1;

    localparam int REG_MODE_BIT    = 7;
    localparam int REG_INHIBIT_BIT = 6;

endpackage

// File: rtl/frame_divider.sv
// Frame-sequencer prescaler: counts 0..QUARTER_CYCLES-1 and flags the last
// count as a one-cycle step tick; a synchronous clear restarts it from 0.
module frame_divider
    import apu_pkg::*;
#(
    parameter int QUARTER_CYCLES = QUARTER_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(QUARTER_CYCLES - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/frame_sequencer.sv
// APU $4017 frame sequencer: 4/5-step quarter/half-frame strobes and the frame
// interrupt. Define FRAME_IRQ_EN to build the IRQ flag; otherwise frame_irq is 0.
module frame_sequencer
    import apu_pkg::*;
#(
    parameter int QUARTER_CYCLES = QUARTER_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] reg_4017,
    input  logic       reg_4017_event,
    input  logic       status_read,
    output logic       enable_240hz,
    output logic       enable_120hz,
    output logic       frame_irq
);

    logic  tick;
    step_e state_q, state_d;
    logic  mode_q, mode_d;
    logic  q240_q, q240_d;
    logic  q120_q, q120_d;
    logic  unused_reg_bits;

    frame_divider #(
        .QUARTER_CYCLES(QUARTER_CYCLES)
    ) u_divider (
        .clk  (clk),
        .rst  (rst),
        .clear(reg_4017_event),
        .tick (tick)
    );

`ifdef FRAME_IRQ_EN
    logic inhibit_q, inhibit_d;
    logic irq_q, irq_d;
    logic irq_set;
    assign unused_reg_bits = ^reg_4017[5:0];
`else
    assign unused_reg_bits = ^{reg_4017[5:0], reg_4017[REG_INHIBIT_BIT], status_read};
`endif

    // A register write takes priority over a coincident step tick.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        q240_d  = 1'b0;
        q120_d  = 1'b0;
`ifdef FRAME_IRQ_EN
        inhibit_d = inhibit_q;
        irq_set   = 1'b0;
`endif
        if (reg_4017_event) begin
            mode_d  = reg_4017[REG_MODE_BIT];
            state_d = S0;
            if (reg_4017[REG_MODE_BIT] == MODE_5STEP) begin
                q240_d = 1'b1;
                q120_d = 1'b1;
            end
`ifdef FRAME_IRQ_EN
            inhibit_d = reg_4017[REG_INHIBIT_BIT];
`endif
        end else if (tick) begin
            case (state_q)
                S0: begin
                    q240_d  = 1'b1;
                    state_d = S1;
                end
                S1: begin
                    q240_d  = 1'b1;
                    q120_d  = 1'b1;
                    state_d = S2;
                end
                S2: begin
                    q240_d  = 1'b1;
                    state_d = S3;
                end
                S3: begin
                    if (mode_q == MODE_5STEP) begin
                        state_d = S4;
                    end else begin
                        q240_d  = 1'b1;
                        q120_d  = 1'b1;
                        state_d = S0;
`ifdef FRAME_IRQ_EN
                        irq_set = ~inhibit_q;
`endif
                    end
                end
                S4: begin
                    q240_d  = 1'b1;
                    q120_d  = 1'b1;
                    state_d = S0;
                end
                default: state_d = S0;
            endcase
        end
    end

`ifdef FRAME_IRQ_EN
    // Setting the flag beats a simultaneous status read.
    always_comb begin
        irq_d = irq_q;
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (status_read || (reg_4017_event && reg_4017[REG_INHIBIT_BIT])) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inhibit_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            inhibit_q <= inhibit_d;
            irq_q     <= irq_d;
        end
    end

    assign frame_irq = irq_q;
`else
    assign frame_irq = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
            mode_q  <= MODE_4STEP;
            q240_q  <= 1'b0;
            q120_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            q240_q  <= q240_d;
            q120_q  <= q120_d;
        end
    end

    assign enable_240hz = q240_q;
    assign enable_120hz = q120_q;

endmodule
